// File: rtl/hazard_controller.sv
// hazard_controller: per-stage stall/squash/bubble generation for a five-stage pipeline
// Ports: clk_i/rst_ni clock and sync active-low reset; id_*/ex_* stage hazard info;
// mem_trap_i trap at MEM; imem/div/dmem busy inputs; stall_o/squash_o/bubble_o per
// stage (bit 0 = IF .. bit 4 = WB); fetch_redirect_o one-shot redirect; if_discard_o
// drop stale fetch response; perf_stall_cnt_o/perf_flush_cnt_o saturating counters.
module hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_redirect_i,
    input  logic             mem_trap_i,
    input  logic             imem_busy_i,
    input  logic             div_busy_i,
    input  logic             dmem_busy_i,
    output logic [4:0]       stall_o,
    output logic [4:0]       squash_o,
    output logic [4:0]       bubble_o,
    output logic             fetch_redirect_o,
    output logic             if_discard_o,
    output logic [CNT_W-1:0] perf_stall_cnt_o,
    output logic [CNT_W-1:0] perf_flush_cnt_o
);
    typedef enum logic {RUN, DISCARD} state_t;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    state_t           r_state, w_state_nxt;
    logic             r_redirect_done;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_redir, w_lu, w_flush;
    assign w_redir = ex_redirect_i & ex_valid_i & ~mem_trap_i;
    assign w_lu = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                  ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) | (id_uses_rs2_i & (id_rs2_i == ex_rd_i))) &
                  ~w_redir & ~mem_trap_i;
    // Deeper stall sources freeze every older stage and inject a bubble just downstream.
    assign stall_o = !rst_ni ? 5'b00000 : dmem_busy_i ? 5'b01111 : div_busy_i ? 5'b00111 :
                     w_lu ? 5'b00011 : imem_busy_i ? 5'b00001 : 5'b00000;
    assign bubble_o = !rst_ni ? 5'b00000 : dmem_busy_i ? 5'b10000 : div_busy_i ? 5'b01000 :
                      w_lu ? 5'b00100 : imem_busy_i ? 5'b00010 : 5'b00000;
    assign squash_o = !rst_ni ? 5'b11111 : mem_trap_i ? 5'b01111 : w_redir ? 5'b00011 : 5'b00000;
    // A redirect parked in a stalled EX must only steer fetch once.
    assign fetch_redirect_o = rst_ni & w_redir & ~r_redirect_done;
    assign if_discard_o = rst_ni & (r_state == DISCARD) & ~imem_busy_i;
    assign w_flush = fetch_redirect_o | mem_trap_i;
    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_flush_cnt_o = r_flush_cnt;
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == RUN) w_state_nxt = (w_flush & imem_busy_i) ? DISCARD : RUN;
        else w_state_nxt = (~imem_busy_i & ~w_flush) ? RUN : DISCARD;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state         <= RUN;
            r_redirect_done <= 1'b0;
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_redirect_done <= (~stall_o[2] | mem_trap_i) ? 1'b0 : (fetch_redirect_o | r_redirect_done);
            if (stall_o[0] && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + ONE;
            if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + ONE;
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scoreboard bench for hazard_controller (CNT_W = 4)
module tb_hazard_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_u1, id_u2, ex_valid, ex_load, ex_redir, trap, imem, div, dmem;
    logic [4:0] rs1, rs2, rd;
    logic [4:0] stall, squash, bubble;
    logic       fr, disc;
    logic [3:0] pstall, pflush;
    int         n_chk = 0;
    int         n_pass = 0;

    typedef struct {
        string      name;
        logic [4:0] st, sq, bu;
        logic       fr, di;
        logic [3:0] ps, pf;
    } exp_t;
    exp_t q[$];

    hazard_controller #(.CNT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_uses_rs1_i(id_u1), .id_uses_rs2_i(id_u2),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_load), .ex_rd_i(rd),
        .ex_redirect_i(ex_redir), .mem_trap_i(trap),
        .imem_busy_i(imem), .div_busy_i(div), .dmem_busy_i(dmem),
        .stall_o(stall), .squash_o(squash), .bubble_o(bubble),
        .fetch_redirect_o(fr), .if_discard_o(disc),
        .perf_stall_cnt_o(pstall), .perf_flush_cnt_o(pflush)
    );

    always #5 clk = ~clk;

    task automatic clr();
        id_valid = 0; id_u1 = 0; id_u2 = 0; ex_valid = 0; ex_load = 0; ex_redir = 0;
        trap = 0; imem = 0; div = 0; dmem = 0; rs1 = 0; rs2 = 0; rd = 0;
    endtask

    // Push the expected response for the inputs currently applied, then advance one cycle.
    task automatic chk(input string n, input logic [4:0] st, sq, bu, input logic f, d,
                       input int ps, pf);
        exp_t e;
        e.name = n; e.st = st; e.sq = sq; e.bu = bu; e.fr = f; e.di = d;
        e.ps = 4'(ps); e.pf = 4'(pf);
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                n_chk++;
                if ({stall, squash, bubble, fr, disc, pstall, pflush} ==
                    {e.st, e.sq, e.bu, e.fr, e.di, e.ps, e.pf})
                    n_pass++;
                else
                    $display("FAIL %s: got st=%b sq=%b bu=%b fr=%b di=%b ps=%0d pf=%0d want st=%b sq=%b bu=%b fr=%b di=%b ps=%0d pf=%0d",
                             e.name, stall, squash, bubble, fr, disc, pstall, pflush,
                             e.st, e.sq, e.bu, e.fr, e.di, e.ps, e.pf);
            end
        end
    end

    initial begin
        clr();
        rst_n = 0;
        @(posedge clk); #1;
        chk("reset", 5'b00000, 5'b11111, 5'b00000, 0, 0, 0, 0);
        rst_n = 1;
        chk("idle", 0, 0, 0, 0, 0, 0, 0);
        id_valid = 1; ex_valid = 1; ex_load = 1; rd = 5; rs2 = 5; id_u2 = 1;
        chk("lu_rs2", 5'b00011, 0, 5'b00100, 0, 0, 0, 0);
        rd = 0;
        chk("lu_x0", 0, 0, 0, 0, 0, 1, 0);
        clr(); dmem = 1; div = 1; imem = 1;
        chk("prio_dmem", 5'b01111, 0, 5'b10000, 0, 0, 1, 0);
        dmem = 0;
        chk("prio_div", 5'b00111, 0, 5'b01000, 0, 0, 2, 0);
        div = 0; id_valid = 1; ex_valid = 1; ex_load = 1; rd = 7; rs1 = 7; id_u1 = 1;
        chk("prio_lu_rs1", 5'b00011, 0, 5'b00100, 0, 0, 3, 0);
        clr(); imem = 1;
        chk("imem_only", 5'b00001, 0, 5'b00010, 0, 0, 4, 0);
        clr(); ex_valid = 1; ex_redir = 1; div = 1;
        chk("redir_stall1", 5'b00111, 5'b00011, 5'b01000, 1, 0, 5, 0);
        chk("redir_stall2", 5'b00111, 5'b00011, 5'b01000, 0, 0, 6, 1);
        chk("redir_stall3", 5'b00111, 5'b00011, 5'b01000, 0, 0, 7, 1);
        div = 0;
        chk("redir_stall4", 0, 5'b00011, 0, 0, 0, 8, 1);
        clr();
        chk("idle2", 0, 0, 0, 0, 0, 8, 1);
        ex_valid = 1; ex_redir = 1; imem = 1;
        chk("disc_redir", 5'b00001, 5'b00011, 5'b00010, 1, 0, 8, 1);
        clr(); imem = 1;
        chk("disc_wait1", 5'b00001, 0, 5'b00010, 0, 0, 9, 2);
        chk("disc_wait2", 5'b00001, 0, 5'b00010, 0, 0, 10, 2);
        imem = 0;
        chk("disc_drop", 0, 0, 0, 0, 1, 11, 2);
        imem = 1;
        chk("run_busy", 5'b00001, 0, 5'b00010, 0, 0, 11, 2);
        imem = 0;
        chk("run_no_disc", 0, 0, 0, 0, 0, 12, 2);
        trap = 1; ex_valid = 1; ex_redir = 1;
        chk("trap_wins", 0, 5'b01111, 0, 0, 0, 12, 2);
        clr(); trap = 1; imem = 1;
        chk("trap_disc1", 5'b00001, 5'b01111, 5'b00010, 0, 0, 12, 3);
        chk("trap_disc2", 5'b00001, 5'b01111, 5'b00010, 0, 0, 13, 4);
        clr();
        chk("trap_drop", 0, 0, 0, 0, 1, 14, 5);
        id_valid = 1; ex_valid = 1; ex_load = 1; rd = 3; rs1 = 3; id_u1 = 1; ex_redir = 1;
        chk("lu_vs_redir", 0, 5'b00011, 0, 1, 0, 14, 5);
        clr(); imem = 1;
        for (int i = 0; i < 20; i++)
            chk("sat", 5'b00001, 0, 5'b00010, 0, 0, (14 + i > 15) ? 15 : 14 + i, 6);
        clr();
        chk("sat_hold", 0, 0, 0, 0, 0, 15, 6);
        rst_n = 0; imem = 1; ex_valid = 1; ex_redir = 1;
        chk("mid_reset", 0, 5'b11111, 0, 0, 0, 15, 6);
        rst_n = 1; clr();
        chk("post_reset", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central pipeline-control block for the five-stage core (IF, ID, EX, MEM, WB). It turns hazard conditions into the per-stage `stall`, `squash` and `bubble` signals consumed by each stage's validity tracker:

- load-use dependences
- multi-cycle EX operations
- instruction and data memory waits
- branch redirects
- traps

It also issues a one-shot fetch redirect, discards a stale in-flight fetch after a flush, and keeps two saturating performance counters.

## Interface
Parameters
- `CNT_W`, default 32: width of each performance counter.

Ports
- `clk_i`  in  1: core clock.
- `rst_ni`  in  1: reset, synchronous, active-low.
- `id_valid_i`  in  1: ID holds a valid instruction.
- `id_rs1_i`, `id_rs2_i`  in  5 each: ID source register indices.
- `id_uses_rs1_i`, `id_uses_rs2_i`  in  1 each: ID actually reads rs1 / rs2.
- `ex_valid_i`  in  1: EX holds a valid instruction.
- `ex_is_load_i`  in  1: the EX instruction is a load.
- `ex_rd_i`  in  5: EX destination register.
- `ex_redirect_i`  in  1: EX resolved a taken or mispredicted control transfer.
- `mem_trap_i`  in  1: trap taken at MEM (already qualified by MEM validity).
- `imem_busy_i`  in  1: fetch response outstanding.
- `div_busy_i`  in  1: EX multi-cycle unit busy.
- `dmem_busy_i`  in  1: MEM waiting on data memory.
- `stall_o`  out  5: per-stage stall; bit 0 = IF, 1 = ID, 2 = EX, 3 = MEM, 4 = WB.
- `squash_o`  out  5: per-stage squash, same bit order.
- `bubble_o`  out  5: per-stage bubble, same bit order.
- `fetch_redirect_o`  out  1: one-cycle pulse telling fetch to load the EX target PC.
- `if_discard_o`  out  1: drop the fetch response returning this cycle.
- `perf_stall_cnt_o`  out  `CNT_W`: cycles with `stall_o[0]` high.
- `perf_flush_cnt_o`  out  `CNT_W`: count of `fetch_redirect_o` pulses plus trap cycles.

## Operation
Qualified events:
- `trap` = `mem_trap_i`.
- `redir` = `ex_redirect_i & ex_valid_i & ~mem_trap_i`. Trap wins over redirect.
- `lu` (load-use) = `id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_i != 0) & ((id_uses_rs1_i & id_rs1_i == ex_rd_i) | (id_uses_rs2_i & id_rs2_i == ex_rd_i)) & ~redir & ~trap`.

Stall/bubble generation uses strict priority; only the first true row applies, and all other bits are 0:
1. `dmem_busy_i`: `stall_o[3:0]` = 1, `bubble_o[4]` = 1.
2. `div_busy_i`: `stall_o[2:0]` = 1, `bubble_o[3]` = 1.
3. `lu`: `stall_o[1:0]` = 1, `bubble_o[2]` = 1.
4. `imem_busy_i`: `stall_o[0]` = 1, `bubble_o[1]` = 1.

Fixed bits: `stall_o[4]` = 0 and `bubble_o[0]` = 0 always.

Squash generation is independent of stall priority; both may be asserted together:
- `trap` sets `squash_o[3:0]` = 1.
- Otherwise `redir` sets `squash_o[1:0]` = 1.
- `squash_o[4]` = 0 always.

Redirect one-shot:
- Register `redirect_done`.
- `fetch_redirect_o` = `redir & ~redirect_done`.
- `redirect_done` is set when `fetch_redirect_o & stall_o[2]`.
- `redirect_done` is cleared when `~stall_o[2]` or `trap`. Clear has priority.
- Effect: a redirect held in a stalled EX pulses exactly once.

Discard FSM, states RUN and DISCARD:
- RUN to DISCARD: (`fetch_redirect_o` | `trap`) & `imem_busy_i`.
- DISCARD to RUN: `~imem_busy_i` with no new flush event. A new flush while `imem_busy_i` is high keeps the FSM in DISCARD.
- `if_discard_o` = (state == DISCARD) & `~imem_busy_i`.

Counters:
- `perf_stall_cnt_o` += 1 on each cycle with `stall_o[0]` high.
- `perf_flush_cnt_o` += 1 on each cycle with `fetch_redirect_o | trap`.
- Both saturate at 2^`CNT_W`−1 and never wrap.

While `rst_ni` = 0:
- `squash_o` = 5'b11111.
- `stall_o`, `bubble_o`, `fetch_redirect_o` and `if_discard_o` all 0.

## Timing
- `stall_o`, `squash_o`, `bubble_o`, `fetch_redirect_o` and `if_discard_o` are combinational, zero latency from inputs and current state.
- State updates on `posedge clk_i`: FSM, `redirect_done`, counters.
- Reset values: FSM = RUN, `redirect_done` = 0, both counters = 0. Counter outputs read 0 on the first cycle after reset.
- Reset asserted mid-operation: FSM returns to RUN, any pending discard is abandoned, counters clear on that edge.
- Simultaneous `dmem_busy_i` and `div_busy_i`: the row-1 pattern only.
- `lu` coincident with `redir`: `lu` is suppressed, so there is no EX bubble and ID is squashed.
- Trap while DISCARD is already active: the FSM stays in DISCARD and the flush counter still increments.

## Test plan
- Load-use: EX load with `ex_rd_i` = 5, ID `rs2` = 5, `id_uses_rs2_i` = 1 → `stall_o` = 00011, `bubble_o` = 00100. Same stimulus with `ex_rd_i` = 0 → all outputs 0.
- Priority: `dmem_busy_i` = `div_busy_i` = `imem_busy_i` = 1 → `stall_o` = 01111, `bubble_o` = 10000.
- Redirect under stall: `redir` held 4 cycles with `div_busy_i` = 1 for the first 3 → `fetch_redirect_o` high on cycle 1 only, `squash_o` = 00011 on all 4 cycles, `perf_flush_cnt_o` = 1.
- Discard: redirect while `imem_busy_i` = 1; `imem_busy_i` drops 2 cycles later → `if_discard_o` high on exactly that cycle, FSM back in RUN the next cycle.
- Trap beats redirect: `mem_trap_i` = `ex_redirect_i` = 1 → `squash_o` = 01111, `fetch_redirect_o` = 0.
- Saturation and reset: with `CNT_W` = 4, 20 IF-stall cycles → `perf_stall_cnt_o` = 15. Then `rst_ni` = 0 for 1 cycle → counter 0, `squash_o` = 11111 during reset.
